// File: rtl/m3_speedrampctrl_pkg.sv
// Shared encodings and period limits for the m3 speed ramp sequencer.
// The period limits must match the calculator's slice-period max and clock-period min.
package m3_speedrampctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_RAMPDOWN  = 3'd2,
        ST_REVERSE   = 3'd3,
        ST_STOPPING  = 3'd4
    } state_e;

    typedef enum logic {
        RSN_REV  = 1'b0,
        RSN_STOP = 1'b1
    } reason_e;

    localparam logic [31:0] TICK_DIV_DEF     = 32'd100000;
    localparam logic [31:0] PERIOD_MAX_DEF   = 32'd1000000;
    localparam logic [31:0] PERIOD_MIN_DEF   = 32'd40;
    localparam logic [15:0] RAMP_TIMEOUT_DEF = 16'd4096;

    function automatic logic [31:0] clamp_len(input logic [31:0] v,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

endpackage

// File: rtl/m3_speedrampctrl_if.sv
// Host and calculator-facing signals of the speed ramp sequencer.
interface m3_speedrampctrl_if;
    logic        start;
    logic        stop;
    logic        force_stop;
    logic        dir_req;
    logic [31:0] target_len;
    logic        target_valid;
    logic [31:0] cur_len;
    logic        working;
    logic        next_calc;
    logic        speed_inc;
    logic        speed_dec;
    logic        inv_rotate;
    logic        at_speed;
    logic        fault;
    logic [2:0]  state;

    modport slave (
        input  start, stop, force_stop, dir_req, target_len, target_valid, cur_len,
        output working, next_calc, speed_inc, speed_dec, inv_rotate, at_speed, fault, state
    );

    modport master (
        output start, stop, force_stop, dir_req, target_len, target_valid, cur_len,
        input  working, next_calc, speed_inc, speed_dec, inv_rotate, at_speed, fault, state
    );
endinterface

// File: rtl/m3_speedrampctrl_tickgen.sv
// Free-running TICK_DIV divider; emits a registered one-cycle pulse at each wrap.
module m3_speedrampctrl_tickgen
    import m3_speedrampctrl_pkg::*;
#(
    parameter logic [31:0] TICK_DIV = TICK_DIV_DEF
) (
    input  logic clkI,
    input  logic nRstI,
    input  logic en,
    input  logic clr,
    output logic pulse
);
    logic [31:0] cnt;

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (clr || !en) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= (cnt == TICK_DIV - 32'd1);
            cnt   <= (cnt == TICK_DIV - 32'd1) ? '0 : cnt + 32'd1;
        end
    end
endmodule

// File: rtl/m3_speedrampctrl.sv
// Closed-loop sequencer driving the m3 speed inc/dec period calculator:
// start/stop, reversal via ramp-down to minimum speed, force-stop and ramp timeout.
module m3_speedrampctrl
    import m3_speedrampctrl_pkg::*;
#(
    parameter logic [31:0] TICK_DIV     = TICK_DIV_DEF,
    parameter logic [31:0] PERIOD_MAX   = PERIOD_MAX_DEF,
    parameter logic [31:0] PERIOD_MIN   = PERIOD_MIN_DEF,
    parameter logic [15:0] RAMP_TIMEOUT = RAMP_TIMEOUT_DEF
) (
    input  logic clkI,
    input  logic nRstI,
    m3_speedrampctrl_if.slave bus
);
    state_e      state_q, state_d;
    reason_e     reason_q, reason_d;
    logic [31:0] tgt_q, tgt_d;
    logic [15:0] ramp_cnt_q, ramp_cnt_d, ramp_inc;
    logic        working_q, working_d;
    logic        inc_q, inc_d, dec_q, dec_d;
    logic        inv_q, inv_d;
    logic        at_speed_q, at_speed_d;
    logic        fault_q, fault_d;
    logic        upd;
    logic [32:0] tgt_hi, cur_lo;
    logic        too_slow, too_fast;

    // The pulse is suppressed as soon as the FSM heads for IDLE, so none leaks into IDLE.
    m3_speedrampctrl_tickgen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clkI (clkI),
        .nRstI(nRstI),
        .en   (state_d != ST_IDLE),
        .clr  (bus.force_stop),
        .pulse(upd)
    );

    // Deadband is tgt/8; sums are 33 bits so they cannot wrap.
    assign tgt_hi   = {1'b0, tgt_q} + {4'b0, tgt_q[31:3]};
    assign cur_lo   = {1'b0, bus.cur_len} + {4'b0, tgt_q[31:3]};
    assign too_slow = {1'b0, bus.cur_len} > tgt_hi;
    assign too_fast = cur_lo < {1'b0, tgt_q};
    assign ramp_inc = (ramp_cnt_q == 16'hFFFF) ? ramp_cnt_q : ramp_cnt_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        reason_d   = reason_q;
        tgt_d      = tgt_q;
        ramp_cnt_d = ramp_cnt_q;
        working_d  = working_q;
        inc_d      = inc_q;
        dec_d      = dec_q;
        inv_d      = inv_q;
        at_speed_d = 1'b0;
        fault_d    = fault_q;
        if (bus.target_valid) tgt_d = clamp_len(bus.target_len, PERIOD_MIN, PERIOD_MAX);
        if (bus.force_stop) begin
            state_d    = ST_IDLE;
            working_d  = 1'b0;
            inc_d      = 1'b0;
            dec_d      = 1'b0;
            ramp_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    working_d  = 1'b0;
                    inc_d      = 1'b0;
                    dec_d      = 1'b0;
                    ramp_cnt_d = '0;
                    if (bus.start) begin
                        state_d   = ST_RUN;
                        working_d = 1'b1;
                        fault_d   = 1'b0;
                        inv_d     = bus.dir_req;
                    end
                end
                ST_RUN: begin
                    working_d  = 1'b1;
                    ramp_cnt_d = '0;
                    if (bus.stop || (bus.dir_req != inv_q)) begin
                        state_d  = ST_RAMPDOWN;
                        reason_d = bus.stop ? RSN_STOP : RSN_REV;
                        if (upd) begin
                            inc_d = 1'b0;
                            dec_d = 1'b1;
                        end
                    end else begin
                        at_speed_d = !too_slow && !too_fast;
                        if (upd) begin
                            inc_d = too_slow;
                            dec_d = too_fast;
                        end
                    end
                end
                ST_RAMPDOWN: begin
                    if (bus.stop) reason_d = RSN_STOP;
                    if (!bus.stop && reason_q == RSN_REV && bus.dir_req == inv_q) begin
                        state_d = ST_RUN;
                    end else if (upd) begin
                        inc_d = 1'b0;
                        dec_d = 1'b1;
                        if (bus.cur_len >= PERIOD_MAX) begin
                            state_d = (reason_d == RSN_STOP) ? ST_STOPPING : ST_REVERSE;
                        end else begin
                            ramp_cnt_d = ramp_inc;
                            if (ramp_inc > RAMP_TIMEOUT) begin
                                fault_d   = 1'b1;
                                state_d   = ST_IDLE;
                                working_d = 1'b0;
                                inc_d     = 1'b0;
                                dec_d     = 1'b0;
                            end
                        end
                    end
                end
                ST_REVERSE: begin
                    inv_d      = ~inv_q;
                    inc_d      = 1'b0;
                    dec_d      = 1'b0;
                    ramp_cnt_d = '0;
                    state_d    = ST_RUN;
                end
                default: begin
                    working_d  = 1'b0;
                    inc_d      = 1'b0;
                    dec_d      = 1'b0;
                    ramp_cnt_d = '0;
                    state_d    = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state_q    <= ST_IDLE;
            reason_q   <= RSN_REV;
            tgt_q      <= PERIOD_MAX;
            ramp_cnt_q <= '0;
            working_q  <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            inv_q      <= 1'b0;
            at_speed_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            reason_q   <= reason_d;
            tgt_q      <= tgt_d;
            ramp_cnt_q <= ramp_cnt_d;
            working_q  <= working_d;
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            inv_q      <= inv_d;
            at_speed_q <= at_speed_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.working    = working_q;
    assign bus.next_calc  = upd;
    assign bus.speed_inc  = inc_q;
    assign bus.speed_dec  = dec_q;
    assign bus.inv_rotate = inv_q;
    assign bus.at_speed   = at_speed_q;
    assign bus.fault      = fault_q;
endmodule
